page_rw_scheduler: RTL and testbench
====================================

// Module: page_rw_scheduler
// PURPOSE
//  Sequences a PAGES-deep paged block RAM as an event FIFO.
//  The writer fills the current page entry by entry and commits it at end-of-event with its entry count.
//  The reader drains committed pages oldest-first, issuing RAM reads and flagging when output data is valid.
//  Sits between the front-end event builder and the RAM; it owns all RAM address, enable and page bookkeeping.
// PARAMETERS
//  PAGES         4   number of pages; power of 2, >=2; PW=clog2(PAGES)
//  DEPTH         16  entries per page; power of 2, <=31; AW=clog2(DEPTH)
//  READ_LATENCY  2   cycles from mem_enb/mem_addrb to valid RAM doutb (1 or 2)
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  wr_en        in   1        write one entry to current page this cycle
//  evt_done     in   1        close current page (counts a same-cycle wr_en)
//  mem_wea      out  1        RAM write enable
//  mem_addra    out  PW+AW    RAM write address {wp, wcnt}
//  wr_full      out  1        all pages committed; writes and evt_done are dropped
//  wr_ovf       out  1        1-cycle pulse: entry dropped (page full or wr_full)
//  rd_start     in   1        request drain of oldest committed page
//  mem_enb      out  1        RAM read enable
//  mem_regceb   out  1        RAM output register enable
//  mem_addrb    out  PW+AW    RAM read address {rp, rcnt}
//  rd_busy      out  1        read FSM not IDLE
//  rd_valid     out  1        RAM doutb holds a valid entry this cycle
//  rd_last      out  1        with rd_valid: final entry of page
//  rd_nent      out  5        entry count of page being read (held until next rd_start)
//  rd_done      out  1        1-cycle pulse: page freed
//  pages_used   out  PW+1     committed pages, including the one being read
// BEHAVIOUR
//  Reset: every output 0; wp=rp=wcnt=0; pages_used=0; FSM=IDLE; stored counts cleared; mem_regceb=1 from first clk after reset.
//  Reset mid-operation aborts any write/read; all page contents are logically discarded; in-flight rd_valid is suppressed.
//  Write side (combinational outputs from registered state):
//  - mem_wea = wr_en & !wr_full & (wcnt<DEPTH).
//  - mem_addra = {wp,wcnt}; wcnt increments on each accepted write.
//  - wr_en with wr_full or wcnt==DEPTH: no write, wr_ovf=1 next cycle.
//  - evt_done & !wr_full:
//    - nent[wp] <= wcnt plus 1 if a same-cycle write was accepted.
//    - wp <= wp+1 (mod PAGES); wcnt <= 0; pages_used increments.
//  - evt_done with wr_full is ignored. A commit of 0 entries is legal.
//  - wr_full = (pages_used==PAGES).
//  Read FSM: IDLE -> ISSUE -> DRAIN -> IDLE.
//  - IDLE: rd_start & pages_used!=0 -> rd_nent <= nent[rp]; rcnt <= 0; go ISSUE.
//    - rd_start otherwise ignored, including while busy.
//  - ISSUE: mem_enb=1, mem_addrb={rp,rcnt}, rcnt++ each cycle for rd_nent cycles, then go DRAIN.
//    - 0-entry page: ISSUE lasts 0 cycles, straight to DRAIN.
//  - Valid pipeline: READ_LATENCY-stage shift of mem_enb, with a parallel last flag.
//    - rd_valid for entry k occurs at cycle t+1+k+READ_LATENCY, where t = the rd_start cycle.
//    - Entries are contiguous; no gaps.
//  - DRAIN: wait until the pipeline is empty. Then rd_done=1, rp <= rp+1 (mod PAGES), pages_used decrements, go IDLE.
//  Simultaneous commit and free in one cycle: pages_used unchanged; wr_full evaluates on registered count.
//  Reader may drain page N while the writer fills page N+1. Writer never touches a committed page (wr_full guard).
//  All pointers wrap modulo PAGES with natural binary rollover.
//  pages_used saturates by construction: it is never > PAGES and never < 0.
// TESTING
//  1. Reset, write 3 entries, evt_done, rd_start.
//     -> mem_addra 0,1,2; pages_used=1; rd_nent=3.
//     -> rd_valid on cycles t+3..t+5 (READ_LATENCY=2); rd_last on the 3rd; rd_done then pages_used=0.
//  2. Commit 4 pages of 1 entry.
//     -> wr_full=1. Next wr_en gives mem_wea=0 and wr_ovf pulse. Next evt_done has no effect.
//  3. 17 writes into one page (DEPTH=16).
//     -> 16 mem_wea, 1 wr_ovf. Commit sets nent=16. Read yields 16 rd_valid with addr {0,0..15}.
//  4. Commit a 0-entry page, rd_start.
//     -> no mem_enb, no rd_valid. rd_done within READ_LATENCY+2 cycles. pages_used back to 0.
//  5. pages_used=4, reader finishing while evt_done arrives on the rd_done cycle.
//     -> commit dropped (wr_full registered). Cycle after: wr_full=0 and the next commit lands in the freed page (wp wrapped to 0).
//  6. Assert rst mid-ISSUE of a 10-entry page.
//     -> all outputs 0 immediately (async). No further rd_valid. pages_used=0; wp=rp=0 after release.

Source files
------------

// File: rtl/page_rw_scheduler_if.sv
// rtl/page_rw_scheduler_if.sv - event-builder and RAM port bundle for page_rw_scheduler
interface page_rw_scheduler_if #(
  parameter int PAGES = 4,
  parameter int DEPTH = 16
);
  localparam int PW = $clog2(PAGES);
  localparam int AW = $clog2(DEPTH);

  logic              wr_en;
  logic              evt_done;
  logic              mem_wea;
  logic [PW+AW-1:0]  mem_addra;
  logic              wr_full;
  logic              wr_ovf;
  logic              rd_start;
  logic              mem_enb;
  logic              mem_regceb;
  logic [PW+AW-1:0]  mem_addrb;
  logic              rd_busy;
  logic              rd_valid;
  logic              rd_last;
  logic [4:0]        rd_nent;
  logic              rd_done;
  logic [PW:0]       pages_used;

  modport master (
    output wr_en, evt_done, rd_start,
    input  mem_wea, mem_addra, wr_full, wr_ovf, mem_enb, mem_regceb, mem_addrb,
           rd_busy, rd_valid, rd_last, rd_nent, rd_done, pages_used
  );

  modport slave (
    input  wr_en, evt_done, rd_start,
    output mem_wea, mem_addra, wr_full, wr_ovf, mem_enb, mem_regceb, mem_addrb,
           rd_busy, rd_valid, rd_last, rd_nent, rd_done, pages_used
  );
endinterface

// File: rtl/page_rw_scheduler.sv
// rtl/page_rw_scheduler.sv - paged RAM event FIFO: page writer, committed-page reader, valid pipeline
module page_rw_scheduler #(
  parameter int PAGES        = 4,
  parameter int DEPTH        = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  page_rw_scheduler_if.slave  bus
);
  localparam int PW = $clog2(PAGES);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [PW-1:0]           wp;
  logic [PW-1:0]           rp;
  logic [AW:0]             wcnt;
  logic [AW-1:0]           rcnt;
  logic [PW:0]             pages_used;
  logic [4:0]              nent [PAGES];
  logic [4:0]              nent_rd;
  logic [1:0]              state;
  logic [READ_LATENCY-1:0] vpipe;
  logic [READ_LATENCY-1:0] lpipe;
  logic                    wr_ovf_q;
  logic                    regceb_q;

  logic wr_full;
  logic wr_room;
  logic wr_accept;
  logic commit;
  logic issue;
  logic issue_last;
  logic page_free;

  assign wr_full    = (pages_used == (PW+1)'(PAGES));
  assign wr_room    = !wcnt[AW];
  // Gated by rst so the RAM sees no write strobe while reset is held.
  assign wr_accept  = bus.wr_en & !wr_full & wr_room & !rst;
  assign commit     = bus.evt_done & !wr_full;
  assign issue      = (state == S_ISSUE);
  assign issue_last = issue && (5'(rcnt) == nent_rd - 5'd1);
  assign page_free  = (state == S_DRAIN) && (vpipe == '0);

  assign bus.mem_wea    = wr_accept;
  assign bus.mem_addra  = {wp, wcnt[AW-1:0]};
  assign bus.wr_full    = wr_full;
  assign bus.wr_ovf     = wr_ovf_q;
  assign bus.mem_enb    = issue;
  assign bus.mem_regceb = regceb_q;
  assign bus.mem_addrb  = {rp, rcnt};
  assign bus.rd_busy    = (state != S_IDLE);
  assign bus.rd_valid   = vpipe[READ_LATENCY-1];
  assign bus.rd_last    = lpipe[READ_LATENCY-1];
  assign bus.rd_nent    = nent_rd;
  assign bus.rd_done    = page_free;
  assign bus.pages_used = pages_used;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp         <= '0;
      wcnt       <= '0;
      wr_ovf_q   <= 1'b0;
      regceb_q   <= 1'b0;
      pages_used <= '0;
      for (int i = 0; i < PAGES; i++) nent[i] <= '0;
    end else begin
      regceb_q <= 1'b1;
      wr_ovf_q <= bus.wr_en & (wr_full | !wr_room);
      if (commit) begin
        nent[wp] <= 5'(wcnt) + 5'(wr_accept);
        wp       <= wp + 1'b1;
        wcnt     <= '0;
      end else if (wr_accept) begin
        wcnt <= wcnt + 1'b1;
      end
      // Commit and free in the same cycle cancel; full is judged on the registered count.
      pages_used <= pages_used + (PW+1)'(commit) - (PW+1)'(page_free);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      rp      <= '0;
      rcnt    <= '0;
      nent_rd <= '0;
      vpipe   <= '0;
      lpipe   <= '0;
    end else begin
      vpipe[0] <= issue;
      lpipe[0] <= issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
        lpipe[i] <= lpipe[i-1];
      end
      case (state)
        S_IDLE: begin
          if (bus.rd_start && pages_used != '0) begin
            nent_rd <= nent[rp];
            rcnt    <= '0;
            state   <= (nent[rp] == 5'd0) ? S_DRAIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          rcnt <= rcnt + 1'b1;
          if (issue_last) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (page_free) begin
            rp    <= rp + 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_page_rw_scheduler.sv
// tb/tb_page_rw_scheduler.sv - randomized and directed bench against a page-queue reference model
module tb_page_rw_scheduler;
  localparam int PAGES = 4;
  localparam int DEPTH = 16;
  localparam int RL    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  page_rw_scheduler_if #(.PAGES(PAGES), .DEPTH(DEPTH)) bus ();

  page_rw_scheduler #(.PAGES(PAGES), .DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int cyc;
  int m_wp, m_rp, m_wcnt, m_used, m_ovf, m_regceb;
  int m_nent [PAGES];
  int m_active, m_t0, m_n, m_page, m_done, m_rdnent;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    cyc = 0; m_wp = 0; m_rp = 0; m_wcnt = 0; m_used = 0; m_ovf = 0; m_regceb = 0;
    m_active = 0; m_t0 = 0; m_n = 0; m_page = 0; m_done = 0; m_rdnent = 0;
    for (int i = 0; i < PAGES; i++) m_nent[i] = 0;
  endtask

  // Reset asserted between clock edges: every output must drop at once.
  task automatic do_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.evt_done = 1'b0; bus.rd_start = 1'b0;
    #1;
    check("rst_wea",    bus.mem_wea,    0);
    check("rst_addra",  bus.mem_addra,  0);
    check("rst_full",   bus.wr_full,    0);
    check("rst_ovf",    bus.wr_ovf,     0);
    check("rst_enb",    bus.mem_enb,    0);
    check("rst_regceb", bus.mem_regceb, 0);
    check("rst_addrb",  bus.mem_addrb,  0);
    check("rst_busy",   bus.rd_busy,    0);
    check("rst_valid",  bus.rd_valid,   0);
    check("rst_last",   bus.rd_last,    0);
    check("rst_nent",   bus.rd_nent,    0);
    check("rst_done",   bus.rd_done,    0);
    check("rst_used",   bus.pages_used, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // One clock: drive inputs, compare at negedge, advance the model after posedge.
  task automatic step(input bit we, input bit ed, input bit rs);
    bit full, e_wea, e_enb, e_valid, e_last, e_done, commit, start;
    int k, j;
    bus.wr_en = we; bus.evt_done = ed; bus.rd_start = rs;
    full    = (m_used == PAGES);
    e_wea   = we && !full && (m_wcnt < DEPTH);
    k       = cyc - m_t0 - 1;
    j       = k - RL;
    e_enb   = m_active != 0 && k >= 0 && k < m_n;
    e_valid = m_active != 0 && j >= 0 && j < m_n;
    e_last  = e_valid && j == m_n - 1;
    e_done  = m_active != 0 && cyc == m_done;
    @(negedge clk);
    check("wea",    bus.mem_wea,    int'(e_wea));
    check("addra",  bus.mem_addra,  m_wp * DEPTH + (m_wcnt % DEPTH));
    check("full",   bus.wr_full,    int'(full));
    check("ovf",    bus.wr_ovf,     m_ovf);
    check("enb",    bus.mem_enb,    int'(e_enb));
    if (e_enb) check("addrb", bus.mem_addrb, m_page * DEPTH + k);
    check("regceb", bus.mem_regceb, m_regceb);
    check("busy",   bus.rd_busy,    m_active);
    check("valid",  bus.rd_valid,   int'(e_valid));
    check("last",   bus.rd_last,    int'(e_last));
    check("nent",   bus.rd_nent,    m_rdnent);
    check("done",   bus.rd_done,    int'(e_done));
    check("used",   bus.pages_used, m_used);
    @(posedge clk);
    commit = ed && !full;
    start  = m_active == 0 && rs && m_used != 0;
    m_ovf  = int'(we && (full || m_wcnt == DEPTH));
    if (commit) begin
      m_nent[m_wp] = m_wcnt + int'(e_wea);
      m_wp   = (m_wp + 1) % PAGES;
      m_wcnt = 0;
    end else if (e_wea) begin
      m_wcnt++;
    end
    if (e_done) begin
      m_rp = (m_rp + 1) % PAGES;
      m_active = 0;
    end
    if (start) begin
      m_page = m_rp; m_n = m_nent[m_rp]; m_rdnent = m_n; m_t0 = cyc;
      m_done = (m_n == 0) ? cyc + 1 : cyc + m_n + RL + 1;
      m_active = 1;
    end
    m_used   = m_used + int'(commit) - int'(e_done);
    m_regceb = 1;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 200 && (m_used != 0 || m_active != 0); i++)
      step(1'b0, 1'b0, m_active == 0);
    check("drained", bus.pages_used, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    bus.wr_en = 1'b0; bus.evt_done = 1'b0; bus.rd_start = 1'b0;
    model_clear();
    do_reset();

    // Three entries, commit, read back.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(10);

    // Four one-entry commits fill the RAM; extra write and commit are dropped.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Commit arriving on the free cycle of a full RAM is dropped, next one lands.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20 && m_active != 0; i++) step(1'b0, m_active != 0 && cyc == m_done, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    drain_all();

    // Seventeen writes into one page: one overflow, sixteen entries read.
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    drain_all();

    // Empty page commit and read.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(RL + 3);

    // Randomized traffic with two write-density regimes.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1200; i++) begin
        step($urandom_range(0, 99) < (ph == 0 ? 60 : 90),
             $urandom_range(0, 99) < (ph == 0 ? 10 : 4),
             $urandom_range(0, 99) < 20);
      end
      drain_all();
    end

    // Reset in the middle of issuing a ten-entry page.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #2;
    do_reset();
    idle(8);
    step(1'b1, 1'b1, 1'b0);
    drain_all();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
